// File: rtl/nrisc_regfile_p.sv
// NRISC general-purpose register file: two registered read ports, one write port,
// write-to-read bypass, optional hard-wired zero register and a sequenced clear engine.
module nrisc_regfile_p #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              write,
    input  logic [ADDR_W-1:0] CORE_REG_RD,
    input  logic [DATA_W-1:0] RD,
    input  logic [ADDR_W-1:0] CORE_REG_RF1,
    input  logic [ADDR_W-1:0] CORE_REG_RF2,
    output logic [DATA_W-1:0] RF1,
    output logic [DATA_W-1:0] RF2,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rf1_q, rf1_d;
    logic [DATA_W-1:0] rf2_q, rf2_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              wr_ok_s;
    logic              rf1_zero_s;
    logic              rf2_zero_s;

    // Next-state, clear sequencing, write arbitration and read/bypass selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf1_d      = '0;
        rf2_d      = '0;
        we_s       = 1'b0;
        waddr_s    = CORE_REG_RD;
        wdata_s    = RD;
        rf1_zero_s = (ZERO_R0 != 0) && (CORE_REG_RF1 == '0);
        rf2_zero_s = (ZERO_R0 != 0) && (CORE_REG_RF2 == '0);
        wr_ok_s    = write && !((ZERO_R0 != 0) && (CORE_REG_RD == '0));

        case (state_q)
            S_CLEAR: begin
                // User traffic is ignored; the engine owns the write port.
                we_s    = 1'b1;
                waddr_s = cnt_q;
                wdata_s = '0;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                we_s = wr_ok_s;
                if (rf1_zero_s) begin
                    rf1_d = '0;
                end else if (wr_ok_s && (CORE_REG_RD == CORE_REG_RF1)) begin
                    rf1_d = RD;
                end else begin
                    rf1_d = mem[CORE_REG_RF1];
                end
                if (rf2_zero_s) begin
                    rf2_d = '0;
                end else if (wr_ok_s && (CORE_REG_RD == CORE_REG_RF2)) begin
                    rf2_d = RD;
                end else begin
                    rf2_d = mem[CORE_REG_RF2];
                end
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == S_RUN);
    end

    // Control and read-port registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rf1_q   <= '0;
            rf2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rf1_q   <= rf1_d;
            rf2_q   <= rf2_d;
        end
    end

    // Storage array; contents are only ever zeroed by the clear engine
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    assign RF1   = rf1_q;
    assign RF2   = rf2_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_nrisc_regfile_p.sv
// Scoreboard bench for nrisc_regfile_p: three builds (16x16 zero-r0, 16x16 plain r0, 32x32).
module tb_nrisc_regfile_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus for the two 16x16 builds
    logic        rst, clr, wr;
    logic [3:0]  wa, ra1, ra2;
    logic [15:0] wd;
    logic [15:0] rf1_a, rf2_a, rf1_b, rf2_b;
    logic        rdy_a, rdy_b;

    // Stimulus for the 32x32 build
    logic        rst_c, clr_c, wr_c;
    logic [4:0]  wa_c, ra1_c, ra2_c;
    logic [31:0] wd_c;
    logic [31:0] rf1_c, rf2_c;
    logic        rdy_c;

    nrisc_regfile_p #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr), .write(wr), .CORE_REG_RD(wa), .RD(wd),
        .CORE_REG_RF1(ra1), .CORE_REG_RF2(ra2), .RF1(rf1_a), .RF2(rf2_a), .ready(rdy_a));

    nrisc_regfile_p #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr), .write(wr), .CORE_REG_RD(wa), .RD(wd),
        .CORE_REG_RF1(ra1), .CORE_REG_RF2(ra2), .RF1(rf1_b), .RF2(rf2_b), .ready(rdy_b));

    nrisc_regfile_p #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut_c (
        .clk(clk), .rst(rst_c), .clr_req(clr_c), .write(wr_c), .CORE_REG_RD(wa_c), .RD(wd_c),
        .CORE_REG_RF1(ra1_c), .CORE_REG_RF2(ra2_c), .RF1(rf1_c), .RF2(rf2_c), .ready(rdy_c));

    typedef struct {
        int          dut;
        int          cyc;
        logic [95:0] name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        er;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect the outputs of build 'dut' after 'dly' more clock edges
    task automatic push(input int dut, input int dly, input logic [95:0] nm,
                        input logic [31:0] e1, input logic [31:0] e2, input logic er);
        exp_t e;
        e.dut  = dut;
        e.cyc  = cyc + dly;
        e.name = nm;
        e.e1   = e1;
        e.e2   = e2;
        e.er   = er;
        sb.push_back(e);
    endtask

    exp_t        m_e;
    logic [31:0] g1, g2;
    logic        gr;

    // Monitor: pops every expectation due this cycle and compares against the DUT
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.dut)
                0:       begin g1 = {16'h0, rf1_a}; g2 = {16'h0, rf2_a}; gr = rdy_a; end
                1:       begin g1 = {16'h0, rf1_b}; g2 = {16'h0, rf2_b}; gr = rdy_b; end
                default: begin g1 = rf1_c;          g2 = rf2_c;          gr = rdy_c; end
            endcase
            n_cmp++;
            if (m_e.cyc != cyc || g1 !== m_e.e1 || g2 !== m_e.e2 || gr !== m_e.er) begin
                n_err++;
                $display("FAIL %0s dut%0d cyc=%0d: got rf1=%h rf2=%h ready=%b, want rf1=%h rf2=%h ready=%b (due %0d)",
                         m_e.name, m_e.dut, cyc, g1, g2, gr, m_e.e1, m_e.e2, m_e.er, m_e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; wr = 1'b0; wa = 4'h0; wd = 16'h0; ra1 = 4'h0; ra2 = 4'h0;
        rst_c = 1'b1; clr_c = 1'b0; wr_c = 1'b0; wa_c = 5'h0; wd_c = 32'h0; ra1_c = 5'h0; ra2_c = 5'h0;

        // Reset and the initial 16-cycle clear
        step(); step();
        push(0, 0, "rst_a", 32'h0, 32'h0, 1'b0);
        push(1, 0, "rst_b", 32'h0, 32'h0, 1'b0);
        push(2, 0, "rst_c", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) push(0, k, "clr_a", 32'h0, 32'h0, k == 16);
        push(1, 16, "clr_b", 32'h0, 32'h0, 1'b1);
        repeat (16) step();
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i); ra2 = 4'(15 - i);
            push(0, 1, "rd_zero", 32'h0, 32'h0, 1'b1);
            step();
        end

        // Write then read
        wr = 1'b1; wa = 4'd3; wd = 16'hA5A5; ra1 = 4'd0; ra2 = 4'd0;
        push(0, 1, "wr3", 32'h0, 32'h0, 1'b1);
        step();
        wr = 1'b0; ra1 = 4'd3; ra2 = 4'd4;
        push(0, 1, "rd3", 32'hA5A5, 32'h0, 1'b1);
        push(1, 1, "rd3_b", 32'hA5A5, 32'h0, 1'b1);
        step();

        // Same-cycle bypass
        wr = 1'b1; wa = 4'd5; wd = 16'h1234; ra1 = 4'd3; ra2 = 4'd5;
        push(0, 1, "byp5", 32'hA5A5, 32'h1234, 1'b1);
        push(1, 1, "byp5_b", 32'hA5A5, 32'h1234, 1'b1);
        step();
        wr = 1'b0; ra1 = 4'd5;
        push(0, 1, "rd5", 32'h1234, 32'h1234, 1'b1);
        step();

        // Register 0 behaviour
        wr = 1'b1; wa = 4'd0; wd = 16'hFFFF; ra1 = 4'd0; ra2 = 4'd0;
        push(0, 1, "r0_byp", 32'h0, 32'h0, 1'b1);
        push(1, 1, "r0_byp_b", 32'hFFFF, 32'hFFFF, 1'b1);
        step();
        wr = 1'b0;
        push(0, 1, "r0_rd", 32'h0, 32'h0, 1'b1);
        push(1, 1, "r0_rd_b", 32'hFFFF, 32'hFFFF, 1'b1);
        step();

        // Fill r1..r15, then clear on request with writes and a stray clr_req during the clear
        for (int i = 1; i < 16; i++) begin
            wr = 1'b1; wa = 4'(i); wd = 16'(i) * 16'h1111;
            step();
        end
        wr = 1'b0; ra1 = 4'd7; ra2 = 4'd15;
        push(0, 1, "fill", 32'h7777, 32'hFFFF, 1'b1);
        step();
        clr = 1'b1; wr = 1'b1; wa = 4'd9; wd = 16'hBEEF; ra1 = 4'd9; ra2 = 4'd9;
        push(0, 1, "clrreq", 32'hBEEF, 32'hBEEF, 1'b0);
        push(1, 1, "clrreq_b", 32'hBEEF, 32'hBEEF, 1'b0);
        step();
        wd = 16'hDEAD;
        for (int k = 2; k <= 17; k++) begin
            clr = (k == 10);
            wa = 4'(k); ra1 = 4'(k); ra2 = 4'(k + 1);
            push(0, 1, "clearing", 32'h0, 32'h0, k == 17);
            if (k == 17) push(1, 1, "clr_end_b", 32'h0, 32'h0, 1'b1);
            step();
        end
        clr = 1'b0; wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i); ra2 = 4'(i);
            push(0, 1, "post_clr", 32'h0, 32'h0, 1'b1);
            push(1, 1, "post_clr_b", 32'h0, 32'h0, 1'b1);
            step();
        end

        // Reset in the middle of a clear (cnt=7) restarts the full sequence
        wr = 1'b1; wa = 4'd2; wd = 16'h2222; ra1 = 4'd0; ra2 = 4'd0;
        step();
        wr = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        rst = 1'b1; ra1 = 4'd2; ra2 = 4'd3;
        push(0, 1, "midrst", 32'h0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) push(0, k, "reclr", 32'h0, 32'h0, k == 16);
        repeat (16) step();
        push(0, 1, "reclr_rd", 32'h0, 32'h0, 1'b1);
        step();

        // 32-bit x 32-entry build
        rst_c = 1'b0;
        for (int k = 1; k <= 32; k++) push(2, k, "clr_c", 32'h0, 32'h0, k == 32);
        repeat (32) step();
        wr_c = 1'b1; wa_c = 5'd17; wd_c = 32'hDEADBEEF; ra1_c = 5'd0; ra2_c = 5'd0;
        push(2, 1, "c_wr17", 32'h0, 32'h0, 1'b1);
        step();
        wa_c = 5'd31; wd_c = 32'h80000001; ra1_c = 5'd17; ra2_c = 5'd31;
        push(2, 1, "c_byp31", 32'hDEADBEEF, 32'h80000001, 1'b1);
        step();
        wr_c = 1'b0;
        push(2, 1, "c_rd", 32'hDEADBEEF, 32'h80000001, 1'b1);
        step();
        wr_c = 1'b1; wa_c = 5'd0; wd_c = 32'hFFFFFFFF; ra1_c = 5'd0;
        push(2, 1, "c_r0", 32'h0, 32'h80000001, 1'b1);
        step();
        wr_c = 1'b0; clr_c = 1'b1;
        step();
        clr_c = 1'b0;
        repeat (7) step();
        rst_c = 1'b1;
        push(2, 1, "c_midrst", 32'h0, 32'h0, 1'b0);
        step();
        rst_c = 1'b0;
        for (int k = 1; k <= 32; k++) push(2, k, "c_reclr", 32'h0, 32'h0, k == 32);
        repeat (32) step();
        ra1_c = 5'd17; ra2_c = 5'd31;
        push(2, 1, "c_after", 32'h0, 32'h0, 1'b1);
        step();

        for (int t = 0; t < 10 && sb.size() > 0; t++) step();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
